// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state
// encoding, digit-correction constants and the digit-count sizing helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Smallest digit count whose decimal range covers 2^bin_w - 1.
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned maxv;
        longint unsigned p;
        int unsigned     d;
        maxv = (64'd1 << bin_w) - 64'd1;
        p    = 64'd1;
        d    = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (p <= maxv) begin
                p = p * 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result handshake bundle between the converter and its neighbours.
interface bin2bcd_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, busy
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d + ADJ_ADD;
        end
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one correct-and-shift step per clock,
// valid/ready handshake on both the request and the result side.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic       clk,
    input logic       rst,
    bin2bcd_if.slave  bus
);
    localparam int unsigned SW = 4 * DIGITS + BIN_W;
    localparam int unsigned CW = $clog2(BIN_W + 1);

    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    state_t                state, state_nx;
    logic [CW-1:0]         count;
    logic [SW-1:0]         scratch;
    logic [SW-1:0]         scratch_adj;
    logic [SW-1:0]         shifted;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  rst_q;
    logic                  in_ready;
    logic                  accept;
    logic                  last_step;

    assign scratch_adj[BIN_W-1:0] = scratch[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[BIN_W + 4*g +: 4]),
            .q (scratch_adj[BIN_W + 4*g +: 4])
        );
    end

    assign shifted   = scratch_adj << 1;
    // rst_q keeps in_ready low through reset without a comb path from rst.
    assign in_ready  = (state == IDLE) && !rst_q;
    assign accept    = bus.in_valid && in_ready;
    assign last_step = (count == CW'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)         state_nx = SHIFT;
            SHIFT:   if (last_step)      state_nx = DONE;
            DONE:    if (bus.out_ready)  state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            scratch <= '0;
            bcd_q   <= '0;
            rst_q   <= 1'b1;
        end else begin
            state <= state_nx;
            rst_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        scratch <= {{(4*DIGITS){1'b0}}, bus.bin_in};
                        count   <= CW'(BIN_W);
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    count   <= count - CW'(1);
                    if (last_step) begin
                        bcd_q <= shifted[SW-1 -: 4*DIGITS];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == SHIFT);
    assign bus.bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(8), .DIGITS(3)) bus ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [11:0] ref_bcd(input int n);
        logic [11:0] r;
        r[3:0]  = 4'(n % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[11:8] = 4'((n / 100) % 10);
        return r;
    endfunction

    function automatic bit digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full request/result transaction with optional gaps, back-pressure and
    // ignored in_valid noise while the conversion is running.
    task automatic run_one(input logic [7:0] v, input int gap, input int hold,
                           input bit noise, output logic [11:0] res);
        int n;
        logic [11:0] e;
        logic [11:0] first;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (gap) tick;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait v=%0d in_ready=%b required 1", v, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.bin_in   = v;
        tick;
        exp_q.push_back(ref_bcd(int'(v)));
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.bin_in   = 8'($urandom);
            end
            tick;
            n++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL latency v=%0d edges=%0d required 8", v, n);
        end
        first = bus.bcd_out;
        for (int i = 0; i < hold; i++) begin
            tick;
            total++;
            if (bus.out_valid !== 1'b1 || bus.bcd_out !== first) begin
                bad++;
                $display("FAIL hold v=%0d out_valid=%b bcd=%h required 1/%h",
                         v, bus.out_valid, bus.bcd_out, first);
            end
        end
        res = bus.bcd_out;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        total++;
        if (res !== e) begin
            bad++;
            $display("FAIL result v=%0d bcd=%h required %h", v, res, e);
        end
        total++;
        if (!digits_ok(res)) begin
            bad++;
            $display("FAIL digit_range v=%0d bcd=%h required digits<=9", v, res);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL handoff v=%0d out_valid=%b in_ready=%b required 0/1",
                     v, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bin_in    = 8'd55;
        bus.out_ready = 1'b0;
        tick;
        tick;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bcd_out !== 12'h000
            || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state ov=%b busy=%b bcd=%h rdy=%b required 0/0/000/0",
                     bus.out_valid, bus.busy, bus.bcd_out, bus.in_ready);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick;
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release in_ready=%b busy=%b required 1/0",
                     bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_conversions;
        logic [7:0]  vals[5] = '{8'd0, 8'd9, 8'd99, 8'd128, 8'd255};
        logic [11:0] want[5] = '{12'h000, 12'h009, 12'h099, 12'h128, 12'h255};
        logic [11:0] r;
        for (int i = 0; i < 5; i++) begin
            run_one(vals[i], 0, 0, 1'b0, r);
            total++;
            if (r !== want[i]) begin
                bad++;
                $display("FAIL conv_table v=%0d bcd=%h required %h", vals[i], r, want[i]);
            end
        end
    endtask

    task automatic test_back_pressure;
        int n;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.bin_in    = 8'd173;
        tick;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.bin_in   = 8'd17;
            total++;
            if (bus.out_valid !== 1'b1 || bus.bcd_out !== 12'h173 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold ov=%b bcd=%h rdy=%b required 1/173/0",
                         bus.out_valid, bus.bcd_out, bus.in_ready);
            end
            tick;
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_handoff rdy=%b busy=%b ov=%b required 1/0/0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        tick;
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept busy=%b required 1", bus.busy);
        end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        total++;
        if (bus.out_valid !== 1'b1 || bus.bcd_out !== 12'h017) begin
            bad++;
            $display("FAIL bp_second ov=%b bcd=%h required 1/017", bus.out_valid, bus.bcd_out);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [11:0] r;
        bit seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bin_in    = 8'd200;
        tick;
        bus.in_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.bcd_out !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset busy=%b ov=%b bcd=%h required 0/0/000",
                     bus.busy, bus.out_valid, bus.bcd_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_reset_ghost out_valid_seen=1 required 0");
        end
        run_one(8'd42, 0, 0, 1'b0, r);
        total++;
        if (r !== 12'h042) begin
            bad++;
            $display("FAIL after_reset bcd=%h required 042", r);
        end
    endtask

    task automatic test_sweep;
        logic [11:0] r;
        for (int v = 0; v < 256; v++) begin
            run_one(8'(v), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, r);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sweep_queue leftover=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_chain;
        logic [11:0] r9, r6;
        int s;
        int sum_d;
        int carry;
        run_one(8'd9, 0, 0, 1'b0, r9);
        run_one(8'd6, 0, 0, 1'b0, r6);
        s     = int'(r9[3:0]) + int'(r6[3:0]) + 1;
        carry = (s > 9) ? 1 : 0;
        sum_d = (s > 9) ? s - 10 : s;
        total++;
        if (sum_d != 6 || carry != 1) begin
            bad++;
            $display("FAIL chain_adder sum=%0d carry=%0d required 6/1", sum_d, carry);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;
        test_reset;
        test_conversions;
        test_back_pressure;
        test_reset_mid;
        test_sweep;
        test_chain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter that turns an unsigned binary operand into packed BCD digits, one shift-and-correct step per clock. It sits directly upstream of the BCD adder: each converted result supplies one 4-bit-per-digit operand (`a` or `b`, digit-sliced) to that stage. Valid/ready handshakes on both sides let it be chained or back-pressured by the adder's operand-capture logic.

## Interface
- `BIN_W`, default 8: binary input width; also the conversion length in shift cycles.
- `DIGITS`, default 3: BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1; violation is an elaboration error.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `bin_in` holds a request.
- `in_ready`  out  1  converter can accept a request (IDLE only).
- `bin_in`  in  BIN_W  unsigned binary operand.
- `out_valid`  out  1  `bcd_out` holds a finished result.
- `out_ready`  in  1  downstream consumes result.
- `bcd_out`  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- `busy`  out  1  high in SHIFT.

## Operation
- FSM with three states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: load scratch register {4*DIGITS zeros, `bin_in`}, load count = BIN_W, go to SHIFT.
- **SHIFT**, one step per cycle:
  - Each BCD digit ≥ 5 gets +3 (4-bit, no carry between digits).
  - The whole scratch register then shifts left by 1.
  - Count decrements.
  - On the step where count reaches 0: latch the BCD field into `bcd_out`, go to DONE.
- **DONE**
  - `out_valid` = 1; `bcd_out` is held stable.
  - On `out_ready`: go to IDLE.
- Requests not accepted in IDLE are ignored: `in_valid` is don't-care in SHIFT and DONE, and there is no queueing.
- `bcd_out` changes only on the SHIFT→DONE edge and on reset. It keeps its last value in IDLE.
- Every digit of `bcd_out` is always in the range 0–9.

## Timing
- **Reset:** while `rst` is high on an edge, the next state is IDLE and `bcd_out` = 0, count = 0, scratch = 0.
  - `out_valid` = 0 and `busy` = 0.
  - `in_ready` is forced to 0 during the reset cycle and goes to 1 in the first cycle after `rst` drops.
- **Latency:** accept edge E → `out_valid` high after edge E+BIN_W. With default BIN_W = 8, that is 8 edges.
- **Throughput:** at best one result per BIN_W+2 cycles (accept, BIN_W shifts, handoff).
- **Handoff:** `out_valid & out_ready` at edge F → IDLE after F, so `in_ready` = 1 in cycle F+1. A request is not accepted in the same cycle as handoff.
- **Back-pressure:** `out_ready` low keeps DONE indefinitely with outputs frozen.
- **Reset mid-conversion or in DONE:** aborts immediately. The result is discarded and `bcd_out` is cleared; no partial result is ever presented.
- **Flag timing:** `busy`, `in_ready` and `out_valid` are decoded from registered state with no combinational input→output paths.

## Structure
- **Package `bin2bcd_pkg`:**
  - the state enum (IDLE/SHIFT/DONE);
  - the digit-correction constant (5 threshold, +3);
  - the function computing the minimum DIGITS for a given BIN_W, used by the elaboration check.
- **Sub-module `bcd_digit_adj`:** combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times via generate.
- **Top level:** FSM, count, scratch register and output register.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid` = 1 → `out_valid` = 0, `busy` = 0, `bcd_out` = 12'h000, `in_ready` = 0 during reset. `in_ready` = 1 in the first cycle after release, and nothing is accepted during reset.
- **Conversions with `out_ready` = 1:** `bin_in` = 0, 9, 99, 128, 255 → `bcd_out` = 12'h000, 12'h009, 12'h099, 12'h128, 12'h255. `out_valid` rises exactly 8 edges after each accept edge.
- **Back-pressure:** convert 8'd173 with `out_ready` low for 5 cycles → `out_valid` and `bcd_out` = 12'h173 stay stable. `in_valid` with 8'd17 during this time is ignored (`in_ready` = 0). After `out_ready` pulses, 8'd17 is accepted one cycle later → 12'h017.
- **Reset mid-operation:** assert `rst` on shift step 4 of 8'd200 → IDLE next cycle, `bcd_out` = 12'h000, `out_valid` never rises. A following 8'd42 → 12'h042.
- **Exhaustive sweep:** 0..255 with random `in_valid`/`out_ready` gaps → every result matches a decimal reference model, every digit ≤ 9, no result lost or duplicated.
- **Chain into the adder:** convert 8'd9 and 8'd6, then feed digit 0 of each result plus `cin` = 1 into the BCD adder stage → adder sum digit 6, carry 1 (decimal 16).
